// File: rtl/threshold_pkg.sv
// Shared types and default sizing for the streaming threshold scanner.
package threshold_pkg;

  localparam int unsigned DEF_NUM_BINS      = 256;
  localparam int unsigned DEF_CHUNK_BINS    = 8;
  localparam int unsigned DEF_BIN_W         = 17;
  localparam int unsigned DEF_HIGH_PRIORITY = 1;

  localparam int unsigned IDX_W       = $clog2(DEF_NUM_BINS);
  localparam int unsigned CHUNK_CNT_W = (DEF_NUM_BINS / DEF_CHUNK_BINS > 1) ?
                                        $clog2(DEF_NUM_BINS / DEF_CHUNK_BINS) : 1;

  typedef logic signed [DEF_BIN_W-1:0] bin_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/threshold_chunk_priority.sv
// Combinational priority pick of the non-negative bin within one beat.
module threshold_chunk_priority #(
  parameter int unsigned CHUNK_BINS    = 8,
  parameter int unsigned BIN_W         = 17,
  parameter int unsigned HIGH_PRIORITY = 1,
  localparam int unsigned LOCAL_W      = (CHUNK_BINS > 1) ? $clog2(CHUNK_BINS) : 1
) (
  input  logic [CHUNK_BINS*BIN_W-1:0] chunk,
  output logic                        hit_c,
  output logic [LOCAL_W-1:0]          idx_c
);

  logic [CHUNK_BINS-1:0] nonneg;

  always_comb begin
    nonneg = '0;
    for (int unsigned k = 0; k < CHUNK_BINS; k++) begin
      nonneg[k] = ~chunk[k*BIN_W + BIN_W - 1];
    end
  end

  // Ascending scan: last hit wins for high priority, first hit wins otherwise.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int unsigned k = 0; k < CHUNK_BINS; k++) begin
      if (nonneg[k] && ((HIGH_PRIORITY != 0) || !hit_c)) begin
        hit_c = 1'b1;
        idx_c = LOCAL_W'(k);
      end
    end
  end

endmodule

// File: rtl/threshold_scanner.sv
// Streams a histogram-difference vector in chunks and reports one threshold per frame.
module threshold_scanner
  import threshold_pkg::*;
#(
  parameter int unsigned NUM_BINS      = DEF_NUM_BINS,
  parameter int unsigned CHUNK_BINS    = DEF_CHUNK_BINS,
  parameter int unsigned BIN_W         = DEF_BIN_W,
  parameter int unsigned HIGH_PRIORITY = DEF_HIGH_PRIORITY
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [CHUNK_BINS*BIN_W-1:0]   i_chunk,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [$clog2(NUM_BINS)-1:0]   o_threshold,
  output logic                          o_found,
  output logic                          o_done,
  output logic                          o_busy
);

  localparam int unsigned NUM_CHUNKS  = NUM_BINS / CHUNK_BINS;
  localparam int unsigned CNT_BITS    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned IDX_BITS    = $clog2(NUM_BINS);
  localparam int unsigned LOCAL_BITS  = (CHUNK_BINS > 1) ? $clog2(CHUNK_BINS) : 1;
  localparam int unsigned LOCAL_SHIFT = $clog2(CHUNK_BINS);
  localparam logic [CNT_BITS-1:0] LAST_CHUNK = CNT_BITS'(NUM_CHUNKS - 1);

  state_t                state;
  state_t                state_next;
  logic [CNT_BITS-1:0]   chunk_cnt;
  logic [CNT_BITS-1:0]   chunk_cnt_next;
  logic [IDX_BITS-1:0]   threshold_next;
  logic                  found_next;
  logic                  beat_take;
  logic                  local_hit;
  logic [LOCAL_BITS-1:0] local_idx;
  logic [IDX_BITS-1:0]   abs_idx;

  threshold_chunk_priority #(
    .CHUNK_BINS    (CHUNK_BINS),
    .BIN_W         (BIN_W),
    .HIGH_PRIORITY (HIGH_PRIORITY)
  ) u_chunk_priority (
    .chunk (i_chunk),
    .hit_c (local_hit),
    .idx_c (local_idx)
  );

  // A beat offered alongside i_start belongs to the aborted frame and is dropped.
  assign beat_take = i_valid && (state == SCAN) && !i_start;
  assign abs_idx   = IDX_BITS'(IDX_BITS'(chunk_cnt) << LOCAL_SHIFT) + IDX_BITS'(local_idx);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    chunk_cnt_next = chunk_cnt;
    threshold_next = o_threshold;
    found_next     = o_found;
    if (i_start) begin
      state_next     = SCAN;
      chunk_cnt_next = '0;
      threshold_next = '0;
      found_next     = 1'b0;
    end else begin
      case (state)
        IDLE: state_next = IDLE;
        SCAN: begin
          if (beat_take) begin
            // Later chunks always carry higher indices, so high priority just overwrites.
            if (local_hit && ((HIGH_PRIORITY != 0) || !o_found)) begin
              threshold_next = abs_idx;
              found_next     = 1'b1;
            end
            if (chunk_cnt == LAST_CHUNK) begin
              chunk_cnt_next = '0;
              state_next     = DONE;
            end else begin
              chunk_cnt_next = chunk_cnt + CNT_BITS'(1);
            end
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      chunk_cnt   <= '0;
      o_threshold <= '0;
      o_found     <= 1'b0;
      o_ready     <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      chunk_cnt   <= chunk_cnt_next;
      o_threshold <= threshold_next;
      o_found     <= found_next;
      o_ready     <= (state_next == SCAN);
      o_busy      <= (state_next == SCAN);
      o_done      <= (state_next == DONE);
    end
  end

endmodule

// File: doc/threshold_scanner.md
Name: threshold_scanner

Overview:
- Streaming successor to the single-chunk threshold finder.
- Accepts a full histogram-difference vector (signed bins, typically cumulative count minus target) as a sequence of CHUNK_BINS-wide beats over a valid/ready handshake.
- Tracks the winning non-negative bin across all chunks and reports one absolute threshold index per frame.
- Sits between the histogram RAM readout and the centroid/star-detect thresholding stage.

Parameters:
- NUM_BINS, 256: total bins per frame; power of two, multiple of CHUNK_BINS.
- CHUNK_BINS, 8: bins per input beat; power of two, 1..32.
- BIN_W, 17: bin width in bits, two's complement; MSB is the sign.
- HIGH_PRIORITY, 1: 1 = highest-index non-negative bin wins; 0 = lowest-index non-negative bin wins.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; clears state and begins a new frame.
- i_chunk  in  CHUNK_BINS*BIN_W  bins; bin k occupies bits [(k+1)*BIN_W-1 : k*BIN_W]; lower k is the lower absolute index.
- i_valid  in  1  i_chunk is valid.
- o_ready  out  1  scanner accepts a beat this cycle.
- o_threshold  out  IDX_W  winning absolute bin index (IDX_W = $clog2(NUM_BINS)).
- o_found  out  1  at least one non-negative bin seen in the frame.
- o_done  out  1  one-cycle pulse; o_threshold and o_found are valid.
- o_busy  out  1  frame in progress.

Behaviour:
- Reset (async assert, sync deassert in use) drives: state=IDLE, o_ready=0, o_done=0, o_busy=0, o_threshold=0, o_found=0, chunk counter=0.
- States:
  - IDLE: waits for i_start, then goes to SCAN.
  - SCAN: o_ready=1, o_busy=1.
  - DONE: lasts one cycle, o_done=1, then returns to IDLE.
- Beat accept: a beat is accepted when i_valid && o_ready. Only accepted beats advance the chunk counter (width $clog2(NUM_BINS/CHUNK_BINS), minimum 1).
- Chunk base: chunk counter * CHUNK_BINS.
- Per-beat chunk result (combinational):
  - local_hit = OR over k of ~bin[k][BIN_W-1].
  - local_idx = highest k with sign bit 0 (HIGH_PRIORITY=1) or lowest k (HIGH_PRIORITY=0).
  - abs_idx = base + local_idx, computed in IDX_W bits with no wrap possible.
- Running update on each accepted beat with local_hit:
  - HIGH_PRIORITY=1: always overwrite o_threshold and set o_found. Later chunks have higher indices.
  - HIGH_PRIORITY=0: write only if o_found==0; the first hit locks.
- Bin 0 negative and no hit: o_threshold stays 0 (sentinel). The value is disambiguated by o_found=0.
- Last beat: acceptance moves SCAN to DONE on the next edge. o_done is high in the cycle after the last accept, with final results already registered. Latency from last accept to o_done is exactly 1 cycle.
- o_threshold and o_found hold their values after DONE until the next i_start.
- i_start in IDLE or DONE: clears o_threshold, o_found and the counter; enters SCAN next cycle; o_done is not asserted.
- i_start in SCAN: aborts the frame, clears state, restarts SCAN. Any beat presented in the same cycle is discarded.
- i_valid while not in SCAN: ignored.
- Reset mid-frame: immediate IDLE, all outputs at reset values, no o_done.

Decomposition:
- Package threshold_pkg holds:
  - localparams for IDX_W and CHUNK_CNT_W derived from the defaults;
  - a typedef for a signed bin of BIN_W;
  - an enum for states IDLE/SCAN/DONE.
- One sub-module threshold_chunk_priority (parameters CHUNK_BINS, BIN_W, HIGH_PRIORITY): purely combinational, produces local_hit and local_idx.
- The top level holds the FSM, counter and running registers.

Test Plan:
- Reset/idle: assert i_rst_n=0 mid-SCAN -> o_ready=0, o_busy=0, o_threshold=0, o_found=0 while reset is asserted; no o_done after release.
- Single hit, defaults: 32 beats, all bins negative except absolute bin 77 (chunk 9, k=5) = 17'h00010 -> o_done one cycle after beat 31, o_threshold=77, o_found=1.
- Priority modes: bins 12, 140 and 255 non-negative -> HIGH_PRIORITY=1 gives 255; HIGH_PRIORITY=0 gives 12.
- No hit: all bins 17'h1FFFF -> o_threshold=0, o_found=0, o_done pulses once. Then bin 0 = 0 only -> o_threshold=0, o_found=1.
- Backpressure/gaps: deassert i_valid randomly for 1-5 cycles between beats, hit at bin 200 -> o_threshold=200. Exactly 32 accepts before o_done; the counter never advances on i_valid=0.
- Abort: i_start pulsed after 10 beats of frame A (hit at bin 40), then full frame B with hit at bin 3 -> one o_done only, o_threshold=3 (HIGH_PRIORITY=1, B's only hit).
